// File: rtl/cl_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cl_bridge_pkg
// Description : Shared defaults and state encodings for the cache-line /
//               CPU-word bridge. Holds the default word and line widths,
//               the derived words-per-line count, and the read-side and
//               write-side FSM state types.
// Revision    : 1.0 - initial release
// ============================================================================
package cl_bridge_pkg;

    localparam int c_word_width = 32;
    localparam int c_line_width = 512;
    localparam int c_n          = c_line_width / c_word_width;

    typedef enum logic [0:0] {
        R_EMPTY = 1'b0,
        R_SERVE = 1'b1
    } rd_state_t;

    typedef enum logic [0:0] {
        W_FILL = 1'b0,
        W_PUSH = 1'b1
    } wr_state_t;

endpackage : cl_bridge_pkg
`default_nettype wire

// File: rtl/cl_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : cl_word_packer
// Description : Packs CPU words into one cache line and pushes the line into
//               the DMA write FIFO when full or on flush.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               wr_en, wr_word    - CPU word write
//               flush             - push a partially filled line
//               wr_ready          - a write this cycle is accepted
//               wr_idle           - nothing buffered, no push pending
//               dma_full          - DMA write FIFO full
//               dma_wr_en         - one-cycle push strobe
//               dma_wr_data       - line being pushed (word 0 in the LSBs)
// Revision    : 1.0 - initial release
// ============================================================================
module cl_word_packer
    import cl_bridge_pkg::*;
#(
    parameter int WORD_WIDTH = c_word_width,
    parameter int N          = c_n
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [WORD_WIDTH-1:0]   wr_word,
    input  logic                    flush,
    input  logic                    dma_full,
    output logic                    wr_ready,
    output logic                    wr_idle,
    output logic                    dma_wr_en,
    output logic [N*WORD_WIDTH-1:0] dma_wr_data
);

    localparam int                 c_idx_w = $clog2(N);
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(N - 1);

    wr_state_t                        r_state;
    wr_state_t                        w_state_nxt;
    logic [c_idx_w-1:0]               r_wr_idx;
    logic [N-1:0][WORD_WIDTH-1:0]     r_line;
    logic                             w_store;
    logic                             w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= W_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A write and a flush in the same cycle both land in one line: the word
    // is stored on this edge and the push follows from W_PUSH.
    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_push      = 1'b0;
        case (r_state)
            W_FILL: begin
                if (wr_en) begin
                    w_store = 1'b1;
                    if (r_wr_idx == c_last || flush) begin
                        w_state_nxt = W_PUSH;
                    end
                end else if (flush && r_wr_idx != '0) begin
                    w_state_nxt = W_PUSH;
                end
            end
            W_PUSH: begin
                if (!dma_full) begin
                    w_push      = 1'b1;
                    w_state_nxt = W_FILL;
                end
            end
            default: w_state_nxt = W_FILL;
        endcase
    end

    // The index parks at the last slot rather than wrapping; the push that
    // follows clears it together with the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_line   <= '0;
        end else if (w_push) begin
            r_wr_idx <= '0;
            r_line   <= '0;
        end else if (w_store) begin
            r_line[r_wr_idx] <= wr_word;
            if (r_wr_idx != c_last) begin
                r_wr_idx <= r_wr_idx + c_idx_w'(1);
            end
        end
    end

    assign wr_ready    = (r_state == W_FILL);
    assign wr_idle     = (r_state == W_FILL) && (r_wr_idx == '0);
    // Gated with rst so no strobe escapes while reset is being applied.
    assign dma_wr_en   = w_push & ~rst;
    assign dma_wr_data = r_line;

endmodule : cl_word_packer
`default_nettype wire

// File: rtl/cl_word_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cl_word_bridge
// Description : Bridges DMA cache lines and CPU words. The read path unpacks
//               lines from a first-word-fall-through DMA read FIFO into
//               words on request; the write path packs words into lines.
// Ports       : clk, rst                     - clock, sync active-high reset
//               dma_empty, dma_rd_data,
//               dma_rd_en                    - DMA read FIFO interface
//               dma_full, dma_wr_en,
//               dma_wr_data                  - DMA write FIFO interface
//               rd_req, rd_word, rd_valid,
//               rd_avail                     - CPU read side
//               wr_en, wr_word, wr_ready,
//               flush, wr_idle               - CPU write side
// Revision    : 1.0 - initial release
// ============================================================================
module cl_word_bridge
    import cl_bridge_pkg::*;
#(
    parameter int WORD_WIDTH = c_word_width,
    parameter int LINE_WIDTH = c_line_width
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dma_empty,
    input  logic [LINE_WIDTH-1:0] dma_rd_data,
    output logic                  dma_rd_en,
    input  logic                  dma_full,
    output logic                  dma_wr_en,
    output logic [LINE_WIDTH-1:0] dma_wr_data,
    input  logic                  rd_req,
    output logic [WORD_WIDTH-1:0] rd_word,
    output logic                  rd_valid,
    output logic                  rd_avail,
    input  logic                  wr_en,
    input  logic [WORD_WIDTH-1:0] wr_word,
    output logic                  wr_ready,
    input  logic                  flush,
    output logic                  wr_idle
);

    localparam int                 c_n_words = LINE_WIDTH / WORD_WIDTH;
    localparam int                 c_idx_w   = $clog2(c_n_words);
    localparam logic [c_idx_w-1:0] c_last    = c_idx_w'(c_n_words - 1);

    // ------------------------------------------------------------------
    // Read path: one line buffered, served one word per request.
    // ------------------------------------------------------------------
    rd_state_t                            r_rd_state;
    rd_state_t                            w_rd_state_nxt;
    logic [c_idx_w-1:0]                   r_rd_idx;
    logic [c_n_words-1:0][WORD_WIDTH-1:0] r_rd_line;
    logic [WORD_WIDTH-1:0]                r_rd_word;
    logic                                 r_rd_valid;
    logic                                 w_rd_pop;
    logic                                 w_rd_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_EMPTY;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_pop       = 1'b0;
        w_rd_take      = 1'b0;
        case (r_rd_state)
            R_EMPTY: begin
                if (!dma_empty) begin
                    w_rd_pop       = 1'b1;
                    w_rd_state_nxt = R_SERVE;
                end
            end
            R_SERVE: begin
                if (rd_req) begin
                    w_rd_take = 1'b1;
                    if (r_rd_idx == c_last) begin
                        w_rd_state_nxt = R_EMPTY;
                    end
                end
            end
            default: w_rd_state_nxt = R_EMPTY;
        endcase
    end

    // The FIFO is fall-through, so the line is captured in the pop cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_idx   <= '0;
            r_rd_line  <= '0;
            r_rd_word  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_take;
            if (w_rd_pop) begin
                r_rd_line <= dma_rd_data;
                r_rd_idx  <= '0;
            end else if (w_rd_take) begin
                r_rd_word <= r_rd_line[r_rd_idx];
                r_rd_idx  <= (r_rd_idx == c_last) ? '0 : r_rd_idx + c_idx_w'(1);
            end
        end
    end

    assign dma_rd_en = w_rd_pop & ~rst;
    assign rd_word   = r_rd_word;
    assign rd_valid  = r_rd_valid;
    assign rd_avail  = (r_rd_state == R_SERVE);

    // ------------------------------------------------------------------
    // Write path.
    // ------------------------------------------------------------------
    cl_word_packer #(
        .WORD_WIDTH (WORD_WIDTH),
        .N          (c_n_words)
    ) u_packer (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_word     (wr_word),
        .flush       (flush),
        .dma_full    (dma_full),
        .wr_ready    (wr_ready),
        .wr_idle     (wr_idle),
        .dma_wr_en   (dma_wr_en),
        .dma_wr_data (dma_wr_data)
    );

endmodule : cl_word_bridge
`default_nettype wire

// File: doc/cl_word_bridge.md
CL_WORD_BRIDGE -- requirements
Module: cl_word_bridge

Interface
REQ-001 Parameter WORD_WIDTH, default 32: width in bits of one CPU-side data word.
REQ-002 Parameter LINE_WIDTH, default 512: width in bits of one DMA cache line; must be an integer multiple of WORD_WIDTH.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 dma_empty  in  1  DMA read FIFO empty; 0 means dma_rd_data is valid.
REQ-006 dma_rd_data  in  LINE_WIDTH  head-of-FIFO cache line, first-word-fall-through.
REQ-007 dma_rd_en  out  1  one-cycle pop of the DMA read FIFO.
REQ-008 dma_full  in  1  DMA write FIFO full.
REQ-009 dma_wr_en  out  1  one-cycle push of dma_wr_data.
REQ-010 dma_wr_data  out  LINE_WIDTH  cache line being pushed.
REQ-011 rd_req  in  1  CPU requests the next read word.
REQ-012 rd_word  out  WORD_WIDTH  returned word.
REQ-013 rd_valid  out  1  rd_word is valid this cycle.
REQ-014 rd_avail  out  1  at least one unread word is buffered.
REQ-015 wr_en  in  1  CPU writes wr_word.
REQ-016 wr_word  in  WORD_WIDTH  word to pack.
REQ-017 wr_ready  out  1  a wr_en this cycle is accepted.
REQ-018 flush  in  1  push a partially filled write line.
REQ-019 wr_idle  out  1  write packer empty, with no push pending.

Function
REQ-020 N = LINE_WIDTH/WORD_WIDTH (16 by default); word index k occupies line bits [k*WORD_WIDTH +: WORD_WIDTH], and word 0 is the LSBs.
REQ-021 The read FSM has the states R_EMPTY and R_SERVE.
REQ-022 In R_EMPTY with dma_empty=0, the block asserts dma_rd_en for exactly one cycle, captures dma_rd_data in that same cycle, clears rd_idx to 0, and enters R_SERVE.
REQ-023 rd_avail=1 exactly when the read FSM is in R_SERVE.
REQ-024 rd_req with rd_avail=1 produces rd_valid=1 on the next cycle, with rd_word = word rd_idx; rd_idx then increments.
REQ-025 rd_req with rd_avail=0 is ignored: no rd_valid, no state change.
REQ-026 When word N-1 is consumed, the FSM returns to R_EMPTY; a refill (dma_rd_en) can occur in the following cycle at the earliest.
REQ-027 rd_valid is a one-cycle pulse; rd_word holds its last value when rd_valid=0.
REQ-028 The write FSM has the states W_FILL and W_PUSH.
REQ-029 In W_FILL, wr_ready=1; wr_en stores wr_word at slot wr_idx and wr_idx increments.
REQ-030 The write that fills slot N-1 moves the FSM to W_PUSH.
REQ-031 In W_PUSH, wr_ready=0; in the first cycle with dma_full=0, the block asserts dma_wr_en for one cycle, clears the line buffer and wr_idx, and returns to W_FILL.
REQ-032 flush in W_FILL with wr_idx>0 moves the FSM to W_PUSH; unwritten slots are zero.
REQ-033 flush with wr_idx=0, or flush in W_PUSH, is a no-op.
REQ-034 When wr_en and flush occur in the same cycle in W_FILL, the word is stored first and the line containing it is then pushed.
REQ-035 wr_en while wr_ready=0 is dropped; the CPU must honour wr_ready.
REQ-036 wr_idle=1 exactly when the FSM is in W_FILL with wr_idx=0.
REQ-037 The read and write paths are fully independent and may operate in the same cycle.
REQ-038 dma_rd_en is never asserted while dma_empty=1, and dma_wr_en is never asserted while dma_full=1.
REQ-039 rd_idx and wr_idx are $clog2(N) bits wide and never wrap silently; the FSM transitions at N-1.

Reset
REQ-040 While rst=1 on a clock edge, the block enters R_EMPTY and W_FILL, and the indices and line buffers clear to 0.
REQ-041 Reset values: dma_rd_en=0, dma_wr_en=0, rd_valid=0, rd_avail=0, wr_ready=1, wr_idle=1, and rd_word and dma_wr_data are all-zero.
REQ-042 Reset mid-operation discards buffered read words and unpushed write words; no DMA pulse is emitted in the reset cycle.

Structure
REQ-043 Package cl_bridge_pkg holds the WORD_WIDTH/LINE_WIDTH defaults, the derived N, and the read-state and write-state enum typedefs.
REQ-044 The write path is a sub-module, cl_word_packer, instantiated once; the read path stays inline.

Verification
REQ-045 dma_empty=0 with line = words 0..15 of value 0x1000+k; 16 back-to-back rd_req -> rd_valid on cycles 2..17 with 0x1000..0x100F, exactly one dma_rd_en, and rd_avail=0 after the last word.
REQ-046 16 writes of 0xA0+k with dma_full=0 -> a single dma_wr_en one cycle after the 16th write, with word k=0xA0+k.
REQ-047 dma_full=1 held for 5 cycles after 16 writes -> wr_ready=0 and no dma_wr_en for those 5 cycles; then one push after dma_full falls.
REQ-048 3 writes (0x1,0x2,0x3) then flush -> a pushed line with words 0..2 = 1,2,3 and words 3..15 = 0; a second flush is a no-op.
REQ-049 rst asserted after 8 read words and 5 written words -> rd_avail=0, wr_idle=1, no DMA pulses; the next line is read starting from word 0.
REQ-050 rd_req with dma_empty=1, and wr_en together with flush on word 15 -> no rd_valid; exactly one push containing the 16th word.
